// File: rtl/s2a_sample_packer.sv
// Purpose : packs two I/Q samples per 64-bit S2A buffer word, aligned to system sync.
// Latency : Ien/Idata registered one Sclk after the second sample of a pair (or the FLUSH cycle).
// Backpr. : none; rx_valid is never stalled and the S2A side must drain buffer halves in time.
//
// Ports:
//   Sclk, rst_n      stream clock (rising edge), async active-low reset
//   sync             system sync; high clears phase/holding/drop count, fall starts RUN
//   enable           capture enable, may toggle at any time
//   rx_valid/rx_i/rx_q  one signed I/Q sample per valid cycle
//   test_mode        counter pattern select (only when S2A_PACK_TEST_EN is defined)
//   Ien/Idata        buffer write strobe and packed word {Q1,I1,Q0,I0}
//   running          high while in RUN
//   drop_cnt         saturating count of samples received outside RUN
// Build option: define S2A_PACK_TEST_EN to add the tcnt test-pattern source.
module s2a_sample_packer #(
  parameter int IN_WIDTH  = 12,
  parameter int MSB_ALIGN = 0
) (
  input  logic                Sclk,
  input  logic                rst_n,
  input  logic                sync,
  input  logic                enable,
  input  logic                rx_valid,
  input  logic [IN_WIDTH-1:0] rx_i,
  input  logic [IN_WIDTH-1:0] rx_q,
  input  logic                test_mode,
  output logic                Ien,
  output logic [63:0]         Idata,
  output logic                running,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, FLUSH} state_t;

  localparam int SHIFT = 16 - IN_WIDTH;

  state_t      state, state_nxt;
  logic        phase;
  logic        sync_d;
  logic [31:0] hold_dat;
  logic [15:0] i16, q16;
  logic [31:0] samp_dat;
  logic        accept;
  logic        drop;
  logic        do_flush;
  logic        phase_after;

  // Sample formatting: sign-extend or left-justify into 16 bits.
  always_comb begin
    i16 = 16'($signed(rx_i));
    q16 = 16'($signed(rx_q));
    if (MSB_ALIGN != 0) begin
      i16 = 16'(rx_i) << SHIFT;
      q16 = 16'(rx_q) << SHIFT;
    end
  end

`ifdef S2A_PACK_TEST_EN
  logic [15:0] tcnt;

  // The counter pattern bypasses alignment so the word content is format independent.
  assign samp_dat = test_mode ? {~tcnt, tcnt} : {q16, i16};

  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 16'h0;
    end else if (sync) begin
      tcnt <= 16'h0;
    end else if (accept) begin
      tcnt <= tcnt + 16'h1;
    end
  end
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign samp_dat         = {q16, i16};
`endif

  // sync dominates everything: no sample is taken or dropped while it is high.
  assign accept      = rx_valid && !sync && (state == RUN);
  assign drop        = rx_valid && !sync && (state != RUN);
  assign do_flush    = !sync && (state == FLUSH);
  assign phase_after = accept ? ~phase : phase;

  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sync) begin
      state_nxt = enable ? ARMED : IDLE;
    end else begin
      case (state)
        IDLE:  if (enable) state_nxt = ARMED;
        ARMED: begin
          if (!enable)     state_nxt = IDLE;
          else if (sync_d) state_nxt = RUN;   // sync was high last cycle, low now
        end
        // A sample arriving with the enable drop still counts toward the pair.
        RUN:   if (!enable) state_nxt = phase_after ? FLUSH : IDLE;
        FLUSH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      Ien      <= 1'b0;
      Idata    <= 64'h0;
      running  <= 1'b0;
      drop_cnt <= 16'h0;
      phase    <= 1'b0;
      sync_d   <= 1'b0;
      hold_dat <= 32'h0;
    end else begin
      Ien     <= 1'b0;
      sync_d  <= sync;
      // Registered from the next state so running tracks state==RUN exactly.
      running <= (state_nxt == RUN);
      if (sync) begin
        phase    <= 1'b0;
        hold_dat <= 32'h0;
        drop_cnt <= 16'h0;
      end else begin
        if (accept) begin
          if (!phase) begin
            hold_dat <= samp_dat;
            phase    <= 1'b1;
          end else begin
            Ien   <= 1'b1;
            Idata <= {samp_dat, hold_dat};
            phase <= 1'b0;
          end
        end
        if (do_flush) begin
          Ien      <= 1'b1;
          Idata    <= {32'h0, hold_dat};
          phase    <= 1'b0;
          hold_dat <= 32'h0;
        end
        if (drop && (drop_cnt != 16'hFFFF)) begin
          drop_cnt <= drop_cnt + 16'h1;
        end
      end
    end
  end

endmodule

// File: tb/tb_s2a_sample_packer.sv
module tb_s2a_sample_packer;

  logic        Sclk = 1'b0;
  logic        rst_n, sync, enable, rx_valid, test_mode;
  logic [11:0] rx_i, rx_q;
  logic        Ien_a, Ien_b, running_a, running_b;
  logic [63:0] Idata_a, Idata_b;
  logic [15:0] drop_cnt_a, drop_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 Sclk = ~Sclk;

  s2a_sample_packer #(.IN_WIDTH(12), .MSB_ALIGN(0)) dut_a (
    .Sclk(Sclk), .rst_n(rst_n), .sync(sync), .enable(enable), .rx_valid(rx_valid),
    .rx_i(rx_i), .rx_q(rx_q), .test_mode(test_mode), .Ien(Ien_a), .Idata(Idata_a),
    .running(running_a), .drop_cnt(drop_cnt_a));

  s2a_sample_packer #(.IN_WIDTH(12), .MSB_ALIGN(1)) dut_b (
    .Sclk(Sclk), .rst_n(rst_n), .sync(sync), .enable(enable), .rx_valid(rx_valid),
    .rx_i(rx_i), .rx_q(rx_q), .test_mode(test_mode), .Ien(Ien_b), .Idata(Idata_b),
    .running(running_b), .drop_cnt(drop_cnt_b));

  // ---------------- model ----------------
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [31:0] held_a, held_b;
  bit          held_v = 1'b0;

  function automatic logic [15:0] fmt16(input int v, input bit align);
    int r;
    r = align ? v * 16 : v;   // 16 = 2**(16-IN_WIDTH)
    return r[15:0];
  endfunction

  function automatic logic [31:0] samp32(input int i, input int q, input bit align);
    return {fmt16(q, align), fmt16(i, align)};
  endfunction

  task automatic model_accept(input int i, input int q);
    if (held_v) begin
      exp_a.push_back({samp32(i, q, 1'b0), held_a});
      exp_b.push_back({samp32(i, q, 1'b1), held_b});
      held_v = 1'b0;
    end else begin
      held_a = samp32(i, q, 1'b0);
      held_b = samp32(i, q, 1'b1);
      held_v = 1'b1;
    end
  endtask

  task automatic model_flush();
    if (held_v) begin
      exp_a.push_back({32'h0, held_a});
      exp_b.push_back({32'h0, held_b});
    end
    held_v = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [63:0] last_a = 64'h0, last_b = 64'h0;
  logic        prev_ien_a = 1'b0, prev_ien_b = 1'b0;

  always @(negedge Sclk) begin
    logic [63:0] e;
    if (Ien_a) begin
      chk("ien_a_spacing", {63'h0, prev_ien_a}, 64'h0);
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL ien_a_unexpected: Idata=%h, no word expected", Idata_a);
        last_a = Idata_a;
      end else begin
        e = exp_a.pop_front();
        chk("idata_a", Idata_a, e);
        last_a = e;
      end
    end else begin
      chk("hold_a", Idata_a, last_a);
    end
    prev_ien_a = Ien_a;
    if (Ien_b) begin
      chk("ien_b_spacing", {63'h0, prev_ien_b}, 64'h0);
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL ien_b_unexpected: Idata=%h, no word expected", Idata_b);
        last_b = Idata_b;
      end else begin
        e = exp_b.pop_front();
        chk("idata_b", Idata_b, e);
        last_b = e;
      end
    end else begin
      chk("hold_b", Idata_b, last_b);
    end
    prev_ien_b = Ien_b;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic do_sync();
    sync = 1'b1; tick();
    sync = 1'b0; tick();
  endtask

  task automatic send(input int i, input int q);
    rx_valid = 1'b1;
    rx_i = 12'(i);
    rx_q = 12'(q);
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; enable = 1'b0; rx_valid = 1'b0; test_mode = 1'b0;
    rx_i = 12'h0; rx_q = 12'h0;
    repeat (3) tick();
    chk("rst_ien",     {63'h0, Ien_a}, 64'h0);
    chk("rst_idata",   Idata_a, 64'h0);
    chk("rst_running", {63'h0, running_a}, 64'h0);
    chk("rst_drop",    {48'h0, drop_cnt_a}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Two pairs of signed samples after a sync pulse.
    enable = 1'b1; tick(); tick();
    do_sync();
    chk("running_after_sync", {63'h0, running_a}, 64'h1);
    for (int k = 1; k <= 4; k++) begin
      send(k, -k);
      model_accept(k, -k);
    end
    tick(); tick();
    chk("lit_pair2_a", Idata_a, 64'hFFFC0004_FFFD0003);

    // Extremes, both sample formats.
    send(12'h7FF, -2048); model_accept(12'h7FF, -2048);
    send(12'h7FF, -2048); model_accept(12'h7FF, -2048);
    tick(); tick();
    chk("lit_align_b", Idata_b, 64'h80007FF0_80007FF0);
    chk("lit_ext_a",   Idata_a, 64'hF80007FF_F80007FF);

    // Odd sample count then enable drop -> flush word.
    send(7, 8);   model_accept(7, 8);
    send(9, -10); model_accept(9, -10);
    send(5, -6);  model_accept(5, -6);
    enable = 1'b0;
    tick();
    chk("running_flush", {63'h0, running_a}, 64'h0);
    model_flush();
    tick(); tick(); tick();
    chk("lit_flush_a", Idata_a, 64'h00000000_FFFA0005);

    // Sync in the middle of a pair discards the held sample.
    enable = 1'b1; tick();
    do_sync();
    send(100, 200); model_accept(100, 200);
    sync = 1'b1; tick();
    held_v = 1'b0;
    chk("running_in_sync", {63'h0, running_a}, 64'h0);
    sync = 1'b0; tick();
    send(11, -12); model_accept(11, -12);
    send(13, -14); model_accept(13, -14);
    tick(); tick();
    chk("lit_after_sync_a", Idata_a, 64'hFFF2000D_FFF4000B);

    // Drops while ARMED, sync clear, saturation in IDLE.
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    rx_valid = 1'b1;
    repeat (5) tick();
    rx_valid = 1'b0;
    chk("drop5_a", {48'h0, drop_cnt_a}, 64'd5);
    chk("drop5_b", {48'h0, drop_cnt_b}, 64'd5);
    do_sync();
    chk("drop_cleared", {48'h0, drop_cnt_a}, 64'h0);
    enable = 1'b0; tick();
    rx_valid = 1'b1;
    repeat (70000) tick();
    rx_valid = 1'b0;
    chk("drop_sat_a", {48'h0, drop_cnt_a}, 64'hFFFF);
    chk("drop_sat_b", {48'h0, drop_cnt_b}, 64'hFFFF);

`ifdef S2A_PACK_TEST_EN
    enable = 1'b1; tick();
    do_sync();
    test_mode = 1'b1;
    exp_a.push_back(64'hFFFE0001_FFFF0000); exp_b.push_back(64'hFFFE0001_FFFF0000);
    exp_a.push_back(64'hFFFC0003_FFFD0002); exp_b.push_back(64'hFFFC0003_FFFD0002);
    for (int k = 0; k < 4; k++) send(300 + k, 400 + k);
    test_mode = 1'b0;
    tick(); tick();
`endif

    repeat (4) tick();
    chk("drain_a", 64'(exp_a.size()), 64'h0);
    chk("drain_b", 64'(exp_b.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
